// File: rtl/encdec_div_seq_30ns16ns.sv
// ---------------------------------------------------------------------------
// encdec_div_seq_30ns16ns
// Sequential unsigned restoring divider for the decoder datapath. It undoes
// the encoder's 14x16 -> 30-bit product stage by recovering a 14-bit quotient
// and a 16-bit remainder from a 30-bit product and a 16-bit divisor. It
// produces one quotient bit per clock.
//
// Ports
//   ap_clk, ap_rst_n   clock and synchronous active-low reset
//   in_valid/in_ready  operand handshake (din0 dividend, din1 divisor)
//   out_valid/out_ready result handshake; the result is held while stalled
//   quo, rem           quotient and remainder
//   div_by_zero        din1 was zero for this result
//   overflow           the true quotient does not fit in QUO_WIDTH bits
// ---------------------------------------------------------------------------
module encdec_div_seq_30ns16ns #(
    parameter logic [31:0]  ID        = 32'd1,
    parameter int unsigned  DVD_WIDTH = 30,
    parameter int unsigned  DIV_WIDTH = 16,
    parameter int unsigned  QUO_WIDTH = 14
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DVD_WIDTH-1:0]  din0,
    input  logic [DIV_WIDTH-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUO_WIDTH-1:0]  quo,
    output logic [DIV_WIDTH-1:0]  rem,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int unsigned CNT_W = ($clog2(QUO_WIDTH) > 0) ? $clog2(QUO_WIDTH) : 1;

    // The dividend must split exactly into a divisor-wide high part and a
    // quotient-wide low part. ID is an instance tag only.
    if ((DVD_WIDTH != QUO_WIDTH + DIV_WIDTH) || ($bits(ID) != 32)) begin : g_bad_widths
        $error("encdec_div_seq_30ns16ns: DVD_WIDTH must equal QUO_WIDTH + DIV_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [DIV_WIDTH-1:0]   divisor;
    logic [DIV_WIDTH-1:0]   part_rem;
    // Holds the remaining dividend bits (MSB first); quotient bits fill in from the LSB.
    logic [QUO_WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]       cnt;

    logic [DIV_WIDTH-1:0]   dvd_hi;
    logic [QUO_WIDTH-1:0]   dvd_lo;
    logic [DIV_WIDTH:0]     trial;
    logic [DIV_WIDTH:0]     diff;
    logic                   q_bit;
    logic [DIV_WIDTH-1:0]   next_rem;
    logic [QUO_WIDTH-1:0]   next_q;

    assign dvd_hi = din0[DVD_WIDTH-1 -: DIV_WIDTH];
    assign dvd_lo = din0[QUO_WIDTH-1:0];

    // One restoring step. The partial remainder is always below the divisor,
    // so a successful subtraction always fits back into DIV_WIDTH bits.
    always_comb begin
        trial    = {part_rem, shreg[QUO_WIDTH-1]};
        diff     = trial - {1'b0, divisor};
        q_bit    = (trial >= {1'b0, divisor});
        next_rem = q_bit ? diff[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
        next_q   = {shreg[QUO_WIDTH-2:0], q_bit};
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            divisor     <= '0;
            part_rem    <= '0;
            shreg       <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        divisor  <= din1;
                        in_ready <= 1'b0;
                        if (din1 == '0) begin
                            quo         <= '1;
                            rem         <= din0[DIV_WIDTH-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            state       <= S_DONE;
                        end else if (dvd_hi >= din1) begin
                            // The high part alone already reaches the divisor, so the
                            // quotient would need more than QUO_WIDTH bits.
                            quo         <= '1;
                            rem         <= '1;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            part_rem <= dvd_hi;
                            shreg    <= dvd_lo;
                            cnt      <= CNT_W'(QUO_WIDTH - 1);
                            state    <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    part_rem <= next_rem;
                    shreg    <= next_q;
                    cnt      <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        quo         <= next_q;
                        rem         <= next_rem;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    // out_valid rises one cycle after entering DONE. It then holds
                    // until the result is taken.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encdec_div_seq_30ns16ns.sv
// ---------------------------------------------------------------------------
// tb_encdec_div_seq_30ns16ns
// Self-checking bench for encdec_div_seq_30ns16ns. It runs directed corner
// cases and then randomized operand pairs with random handshake gaps. Every
// result is compared against a plain-arithmetic division model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encdec_div_seq_30ns16ns;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] din0;
    logic [15:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] quo;
    logic [15:0] rem;
    logic        div_by_zero;
    logic        overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    encdec_div_seq_30ns16ns #(
        .ID        (32'd1),
        .DVD_WIDTH (30),
        .DIV_WIDTH (16),
        .QUO_WIDTH (14)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quo         (quo),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 ap_clk = ~ap_clk;

    // Safety net: the bench must never hang.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exhausted, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer division with the saturating error rules.
    task automatic model(input logic [29:0] a, input logic [15:0] b,
                         output logic [13:0] eq, output logic [15:0] er,
                         output logic edz, output logic eov, output int elat);
        longint q;
        if (b == 16'd0) begin
            eq = 14'h3FFF; er = a[15:0]; edz = 1'b1; eov = 1'b0; elat = 1;
        end else begin
            q = longint'(a) / longint'(b);
            if (q >= 16384) begin
                eq = 14'h3FFF; er = 16'hFFFF; edz = 1'b0; eov = 1'b1; elat = 1;
            end else begin
                eq = 14'(q);
                er = 16'(longint'(a) % longint'(b));
                edz = 1'b0; eov = 1'b0; elat = 15;
            end
        end
    endtask

    // Runs one operation. It waits idle_gap cycles, offers the operands, and
    // measures the latency. It then stalls the result for 'hold' cycles, or
    // raises out_ready before out_valid when early_rdy is set.
    task automatic run_op(input logic [29:0] a, input logic [15:0] b,
                          input bit early_rdy, input int idle_gap, input int hold,
                          input string tag);
        logic [13:0] eq;
        logic [15:0] er;
        logic        edz, eov;
        int          elat, n, lat;
        model(a, b, eq, er, edz, eov, elat);
        repeat (idle_gap) @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 100) begin
            chk({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        din0     = 30'($urandom);
        din1     = 16'($urandom);
        if (early_rdy) out_ready = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge ap_clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_quo"}, 64'(quo), 64'(eq));
        chk({tag, "_rem"}, 64'(rem), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
        chk({tag, "_ovf"}, 64'(overflow), 64'(eov));
        chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        if (!early_rdy) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge ap_clk);
                chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
                chk({tag, "_hold_quo"}, 64'(quo), 64'(eq));
                chk({tag, "_hold_rem"}, 64'(rem), 64'(er));
            end
            out_ready = 1'b1;
        end
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_drain_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_retain_quo"}, 64'(quo), 64'(eq));
    endtask

    initial begin
        logic [29:0] a30;
        logic [15:0] b16;
        longint      qa, rr;
        bit          seen;

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quo", 64'(quo), 64'd0);
        chk("rst_rem", 64'(rem), 64'd0);
        chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Directed corners.
        run_op(30'd8369910, 16'd678, 1'b0, 0, 0, "t1_basic");
        run_op(30'd1073725439, 16'd65535, 1'b0, 1, 2, "t2_max");
        run_op(30'd81920, 16'd5, 1'b0, 0, 0, "t3_ovf");
        run_op(30'd5, 16'd0, 1'b0, 0, 0, "t3_dbz");
        run_op(30'd1000, 16'd7, 1'b0, 0, 20, "t4_backpressure");

        // Reset in the middle of CALC discards the operation.
        in_valid = 1'b1;
        din0     = 30'd8369910;
        din1     = 16'd678;
        @(negedge ap_clk);
        chk("t5_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (6) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_quo", 64'(quo), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (out_valid) seen = 1'b1;
        end
        chk("t5_no_output", 64'(seen), 64'd0);
        run_op(30'd8370587, 16'd678, 1'b0, 0, 1, "t5_next");

        // Random operand pairs built as a*b+r, with occasional error cases.
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 3))
                0:       b16 = 16'($urandom_range(1, 15));
                1:       b16 = 16'($urandom_range(65000, 65535));
                default: b16 = 16'($urandom_range(1, 65535));
            endcase
            qa  = longint'($urandom_range(0, 16383));
            rr  = longint'($urandom) % longint'(b16);
            a30 = 30'(qa * longint'(b16) + rr);
            case ($urandom_range(0, 15))
                0: b16 = 16'd0;
                1: a30 = 30'({16'($urandom_range(int'(b16), 65535)), 14'($urandom)});
                default: ;
            endcase
            run_op(a30, b16, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
